// File: rtl/clink_sched_pkg.sv
// Shared types and defaults for the Clink sequencer and its helper blocks.
package clink_sched_pkg;

    localparam int CLINK_DW            = 16;
    localparam int DEF_SEQ_W           = 8;
    localparam int DEF_TIMEOUT_CYC     = 1023;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        WAIT  = 2'd2,
        OUT   = 2'd3
    } sched_state_t;

endpackage

// File: rtl/clink_sched_fifo.sv
// Single-clock FIFO with a count register so full and empty never alias.
// Pushes into a full FIFO and pops from an empty one are dropped.
module clink_sched_fifo #(
    parameter int FIFO_DEPTH = 8,
    parameter int W          = 16
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] head,
    output logic         full,
    output logic         empty
);

    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full    = (count == CW'(FIFO_DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Power-of-two depth lets the pointers wrap on their own.
    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/clink_seq_sched.sv
// Sequencer in front of the Clink LSTM kernel: queues samples, runs one kernel
// step per sample, returns per-step or end-of-sequence results with a watchdog.
//
//   state | meaning
//   IDLE  | waiting for a queued sample
//   START | one-cycle kernel start pulse, FIFO head popped
//   WAIT  | kernel busy, watchdog counting down
//   OUT   | result held on the output stream until accepted
module clink_seq_sched
    import clink_sched_pkg::*;
#(
    parameter int FIFO_DEPTH  = 8,
    parameter int SEQ_W       = DEF_SEQ_W,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input  logic                clock,
    input  logic                reset,
    input  logic [SEQ_W-1:0]    cfg_seq_len,
    input  logic                cfg_emit_all,
    input  logic                clr_err,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [CLINK_DW-1:0] in_data,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [CLINK_DW-1:0] out_data,
    output logic                out_last,
    output logic                clink_start,
    output logic [CLINK_DW-1:0] clink_input,
    output logic                clink_first,
    input  logic                clink_finish,
    input  logic [CLINK_DW-1:0] clink_output,
    output logic                busy,
    output logic                seq_done,
    output logic                err_timeout
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    sched_state_t        state;
    sched_state_t        state_nxt;
    logic [SEQ_W-1:0]    step;
    logic [SEQ_W-1:0]    len_q;
    logic                emit_q;
    logic                rdy_q;
    logic [WD_W-1:0]     wd;

    logic                fifo_push;
    logic                fifo_pop;
    logic                fifo_full;
    logic                fifo_empty;
    logic [CLINK_DW-1:0] fifo_head;

    logic                launch;
    logic                capture;
    logic                accept;
    logic                step_inc;
    logic                step_clr;
    logic                timeout;
    logic                last;

    // rdy_q keeps in_ready low for the first cycle out of reset.
    assign in_ready  = rdy_q & ~fifo_full;
    assign fifo_push = in_valid & in_ready;

    clink_sched_fifo #(
        .FIFO_DEPTH (FIFO_DEPTH),
        .W          (CLINK_DW)
    ) u_fifo (
        .clock (clock),
        .reset (reset),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .din   (in_data),
        .head  (fifo_head),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    always_comb begin
        state_nxt = state;
        launch    = 1'b0;
        fifo_pop  = 1'b0;
        capture   = 1'b0;
        accept    = 1'b0;
        step_inc  = 1'b0;
        step_clr  = 1'b0;
        timeout   = 1'b0;
        last      = (step == len_q - SEQ_W'(1));
        case (state)
            IDLE: begin
                if (!fifo_empty && !out_valid) begin
                    launch    = 1'b1;
                    state_nxt = START;
                end
            end
            START: begin
                fifo_pop  = 1'b1;
                state_nxt = WAIT;
            end
            WAIT: begin
                if (clink_finish) begin
                    if (emit_q || last) begin
                        capture   = 1'b1;
                        state_nxt = OUT;
                    end else begin
                        step_inc  = 1'b1;
                        state_nxt = IDLE;
                    end
                end else if (wd == '0) begin
                    timeout   = 1'b1;
                    step_clr  = 1'b1;
                    state_nxt = IDLE;
                end
            end
            OUT: begin
                if (out_ready) begin
                    accept    = 1'b1;
                    step_clr  = out_last;
                    step_inc  = ~out_last;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            rdy_q       <= 1'b0;
            step        <= '0;
            len_q       <= SEQ_W'(1);
            emit_q      <= 1'b0;
            wd          <= '0;
            clink_input <= '0;
            out_valid   <= 1'b0;
            out_data    <= '0;
            out_last    <= 1'b0;
            err_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            rdy_q <= 1'b1;

            // Input is loaded one cycle early so it is already valid during START.
            if (launch) begin
                clink_input <= fifo_head;
                if (step == '0) begin
                    len_q  <= (cfg_seq_len == '0) ? SEQ_W'(1) : cfg_seq_len;
                    emit_q <= cfg_emit_all;
                end
            end

            if (fifo_pop) begin
                wd <= WD_W'(TIMEOUT_CYC - 1);
            end else if (state == WAIT && wd != '0) begin
                wd <= wd - WD_W'(1);
            end

            if (capture) begin
                out_data  <= clink_output;
                out_last  <= last;
                out_valid <= 1'b1;
            end else if (accept) begin
                out_valid <= 1'b0;
            end

            if (step_clr) begin
                step <= '0;
            end else if (step_inc) begin
                step <= step + SEQ_W'(1);
            end

            if (timeout) begin
                err_timeout <= 1'b1;
            end else if (clr_err) begin
                err_timeout <= 1'b0;
            end
        end
    end

    assign clink_start = (state == START);
    assign clink_first = clink_start & (step == '0);
    assign seq_done    = accept & out_last;
    assign busy        = (state != IDLE) | out_valid;

endmodule

// File: tb/tb_clink_seq_sched.sv
// Scoreboard bench for clink_seq_sched with a behavioural kernel model.
module tb_clink_seq_sched;

    localparam int DEPTH = 8;
    localparam int SW    = 8;
    localparam int TO    = 40;

    logic          clock = 1'b0;
    logic          reset;
    logic [SW-1:0] cfg_seq_len;
    logic          cfg_emit_all;
    logic          clr_err;
    logic          in_valid;
    logic          in_ready;
    logic [15:0]   in_data;
    logic          out_valid;
    logic          out_ready;
    logic [15:0]   out_data;
    logic          out_last;
    logic          clink_start;
    logic [15:0]   clink_input;
    logic          clink_first;
    logic          clink_finish;
    logic [15:0]   clink_output;
    logic          busy;
    logic          seq_done;
    logic          err_timeout;

    always #5 clock = ~clock;

    clink_seq_sched #(
        .FIFO_DEPTH  (DEPTH),
        .SEQ_W       (SW),
        .TIMEOUT_CYC (TO)
    ) dut (
        .clock        (clock),
        .reset        (reset),
        .cfg_seq_len  (cfg_seq_len),
        .cfg_emit_all (cfg_emit_all),
        .clr_err      (clr_err),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .out_valid    (out_valid),
        .out_ready    (out_ready),
        .out_data     (out_data),
        .out_last     (out_last),
        .clink_start  (clink_start),
        .clink_input  (clink_input),
        .clink_first  (clink_first),
        .clink_finish (clink_finish),
        .clink_output (clink_output),
        .busy         (busy),
        .seq_done     (seq_done),
        .err_timeout  (err_timeout)
    );

    typedef struct packed {
        logic [15:0] d;
        logic [15:0] r;
        logic        hang;
        logic        first;
        logic        emit;
    } kent_t;

    typedef struct packed {
        logic [15:0] d;
        logic        last;
    } oent_t;

    kent_t kern_q[$];
    oent_t exp_q[$];

    int n_checks   = 0;
    int n_errors   = 0;
    int st_cnt     = 0;
    int sd_cnt     = 0;
    int acc_cnt    = 0;
    int inflight   = 0;
    int kern_delay = 3;
    int sb_step    = 0;
    int sb_len     = 1;
    logic sb_emit  = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Reference sequencing model, advanced when a sample is accepted.
    task automatic sb_accept(input logic [15:0] d, input logic [15:0] r, input logic hang);
        kent_t k;
        oent_t o;
        logic  lst;
        if (sb_step == 0) begin
            sb_len  = (cfg_seq_len == '0) ? 1 : int'(cfg_seq_len);
            sb_emit = cfg_emit_all;
        end
        k.d     = d;
        k.r     = r;
        k.hang  = hang;
        k.first = (sb_step == 0);
        k.emit  = 1'b0;
        if (hang) begin
            sb_step = 0;
        end else begin
            lst    = (sb_step == sb_len - 1);
            k.emit = sb_emit | lst;
            if (k.emit) begin
                o.d    = r;
                o.last = lst;
                exp_q.push_back(o);
            end
            sb_step = lst ? 0 : sb_step + 1;
        end
        kern_q.push_back(k);
    endtask

    task automatic push_sample(input logic [15:0] d, input logic [15:0] r, input logic hang);
        int   n;
        logic ok;
        inflight++;
        @(posedge clock);
        #1;
        in_valid = 1'b1;
        in_data  = d;
        n  = 0;
        ok = 1'b0;
        while (!ok && n < 500) begin
            @(negedge clock);
            ok = in_ready;
            n++;
        end
        if (ok) begin
            sb_accept(d, r, hang);
            acc_cnt++;
        end else begin
            check("push_timeout", 32'(in_ready), 32'd1);
        end
        @(posedge clock);
        #1;
        in_valid = 1'b0;
        inflight--;
    endtask

    task automatic wait_drain();
        int n = 0;
        while ((exp_q.size() != 0 || kern_q.size() != 0 || inflight != 0 || busy) && n < 3000) begin
            @(negedge clock);
            n++;
        end
        check("drain_timeout", 32'(n < 3000), 32'd1);
        repeat (2) @(negedge clock);
    endtask

    // Kernel model: answers each start after kern_delay cycles; hang entries answer late.
    kent_t kern_k;
    int    kern_dly;
    logic  kern_abort;
    always begin
        @(negedge clock);
        if (!reset && clink_start) begin
            st_cnt++;
            if (kern_q.size() == 0) begin
                check("unexpected_start", 32'(clink_start), 32'd0);
            end else begin
                kern_k = kern_q.pop_front();
                check("clink_input", 32'(clink_input), 32'(kern_k.d));
                check("clink_first", 32'(clink_first), 32'(kern_k.first));
                kern_dly   = kern_k.hang ? TO + 3 : kern_delay;
                kern_abort = 1'b0;
                for (int i = 0; i < kern_dly; i++) begin
                    @(posedge clock);
                    if (reset) begin
                        kern_abort = 1'b1;
                        break;
                    end
                end
                if (!kern_abort) begin
                    #1;
                    clink_finish = 1'b1;
                    clink_output = kern_k.r;
                    @(posedge clock);
                    #1;
                    clink_finish = 1'b0;
                    clink_output = 16'hDEAD;
                    @(negedge clock);
                    check("finish_to_valid", 32'(out_valid), 32'(kern_k.emit));
                end
            end
        end
    end

    oent_t       mon_e;
    logic        stall_q = 1'b0;
    logic [15:0] hold_d;
    logic        hold_l;
    always @(negedge clock) begin
        if (reset) begin
            stall_q = 1'b0;
        end else begin
            if (stall_q) begin
                check("hold_valid", 32'(out_valid), 32'd1);
                check("hold_data", 32'(out_data), 32'(hold_d));
                check("hold_last", 32'(out_last), 32'(hold_l));
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_out", 32'(out_valid), 32'd0);
                end else begin
                    mon_e = exp_q.pop_front();
                    check("out_data", 32'(out_data), 32'(mon_e.d));
                    check("out_last", 32'(out_last), 32'(mon_e.last));
                    check("seq_done", 32'(seq_done), 32'(mon_e.last));
                end
            end else if (seq_done) begin
                check("seq_done_spurious", 32'(seq_done), 32'd0);
            end
            if (seq_done) sd_cnt++;
            stall_q = out_valid && !out_ready;
            hold_d  = out_data;
            hold_l  = out_last;
        end
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "global timeout");
    end

    int st0, sd0, acc0, n, c;

    initial begin
        reset        = 1'b1;
        cfg_seq_len  = SW'(1);
        cfg_emit_all = 1'b1;
        clr_err      = 1'b0;
        in_valid     = 1'b0;
        in_data      = '0;
        out_ready    = 1'b1;
        clink_finish = 1'b0;
        clink_output = '0;
        repeat (3) @(posedge clock);
        #1 reset = 1'b0;

        @(negedge clock);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_start", 32'(clink_start), 32'd0);
        check("rst_err", 32'(err_timeout), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_clink_input", 32'(clink_input), 32'd0);
        @(negedge clock);
        check("rst_in_ready_after", 32'(in_ready), 32'd1);

        // single step, 12-cycle kernel, start latency
        cfg_seq_len  = SW'(1);
        cfg_emit_all = 1'b0;
        kern_delay   = 12;
        st0 = st_cnt; sd0 = sd_cnt;
        push_sample(16'h1234, 16'h0ABC, 1'b0);
        @(negedge clock);
        check("lat_start_n1", 32'(clink_start), 32'd0);
        @(negedge clock);
        check("lat_start_n2", 32'(clink_start), 32'd1);
        wait_drain();
        check("single_starts", 32'(st_cnt - st0), 32'd1);
        check("single_seq_done", 32'(sd_cnt - sd0), 32'd1);

        // many-to-one
        cfg_seq_len  = SW'(4);
        cfg_emit_all = 1'b0;
        kern_delay   = 3;
        st0 = st_cnt; sd0 = sd_cnt;
        for (int i = 1; i <= 4; i++) push_sample(16'h0100 + 16'(i), 16'(i), 1'b0);
        wait_drain();
        check("m2o_starts", 32'(st_cnt - st0), 32'd4);
        check("m2o_seq_done", 32'(sd_cnt - sd0), 32'd1);

        // backpressure with full FIFO
        cfg_seq_len  = SW'(2);
        cfg_emit_all = 1'b1;
        @(posedge clock);
        #1 out_ready = 1'b0;
        acc0 = acc_cnt;
        fork
            begin
                for (int i = 0; i < 10; i++) push_sample(16'h0A00 + 16'(i), 16'hB000 + 16'(i), 1'b0);
            end
        join_none
        repeat (60) @(negedge clock);
        check("bp_accepted", 32'(acc_cnt - acc0), 32'd9);
        check("bp_in_ready", 32'(in_ready), 32'd0);
        check("bp_out_valid", 32'(out_valid), 32'd1);
        check("bp_out_data", 32'(out_data), 32'hB000);
        @(posedge clock);
        #1 out_ready = 1'b1;
        wait_drain();
        check("bp_accepted_all", 32'(acc_cnt - acc0), 32'd10);

        // watchdog timeout
        cfg_seq_len  = SW'(1);
        cfg_emit_all = 1'b1;
        push_sample(16'h0F0F, 16'hFFFF, 1'b1);
        n = 0;
        do begin
            @(negedge clock);
            n++;
        end while (!clink_start && n < 20);
        check("to_start_seen", 32'(clink_start), 32'd1);
        c = 0;
        do begin
            @(negedge clock);
            c++;
        end while (!err_timeout && c < TO + 50);
        check("to_cycles", 32'(c), 32'(TO + 1));
        check("to_no_output", 32'(out_valid), 32'd0);
        check("to_idle", 32'(busy), 32'd0);
        repeat (10) @(negedge clock);
        check("to_late_finish_ignored", 32'(out_valid), 32'd0);
        check("to_sticky", 32'(err_timeout), 32'd1);
        push_sample(16'h2222, 16'h3333, 1'b0);
        wait_drain();
        check("to_sticky_after", 32'(err_timeout), 32'd1);
        @(posedge clock);
        #1 clr_err = 1'b1;
        @(posedge clock);
        #1 clr_err = 1'b0;
        @(negedge clock);
        check("clr_err", 32'(err_timeout), 32'd0);

        // config latched at step 0
        cfg_seq_len  = SW'(3);
        cfg_emit_all = 1'b1;
        st0 = st_cnt; sd0 = sd_cnt;
        for (int i = 0; i < 3; i++) push_sample(16'h0300 + 16'(i), 16'h1300 + 16'(i), 1'b0);
        n = 0;
        while (st_cnt - st0 < 2 && n < 200) begin
            @(negedge clock);
            n++;
        end
        check("cfg_step1_reached", 32'(st_cnt - st0 >= 2), 32'd1);
        cfg_seq_len = SW'(5);
        for (int i = 0; i < 5; i++) push_sample(16'h0500 + 16'(i), 16'h1500 + 16'(i), 1'b0);
        wait_drain();
        check("cfg_seq_done", 32'(sd_cnt - sd0), 32'd2);

        // seq_len 0 behaves as 1
        cfg_seq_len  = SW'(0);
        cfg_emit_all = 1'b0;
        sd0 = sd_cnt;
        for (int i = 0; i < 3; i++) push_sample(16'h0000 + 16'(i), 16'h2000 + 16'(i), 1'b0);
        wait_drain();
        check("len0_seq_done", 32'(sd_cnt - sd0), 32'd3);

        // reset while kernel is running and samples are queued
        cfg_seq_len  = SW'(1);
        cfg_emit_all = 1'b1;
        kern_delay   = 40;
        for (int i = 0; i < 4; i++) push_sample(16'h0700 + 16'(i), 16'h1700 + 16'(i), 1'b0);
        repeat (4) @(negedge clock);
        check("mid_busy", 32'(busy), 32'd1);
        @(posedge clock);
        #1 reset = 1'b1;
        exp_q.delete();
        kern_q.delete();
        sb_step = 0;
        @(posedge clock);
        #1 reset = 1'b0;
        @(negedge clock);
        check("mid_rst_out_valid", 32'(out_valid), 32'd0);
        check("mid_rst_start", 32'(clink_start), 32'd0);
        check("mid_rst_busy", 32'(busy), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        check("mid_rst_clink_input", 32'(clink_input), 32'd0);
        check("mid_rst_out_data", 32'(out_data), 32'd0);
        check("mid_rst_out_last", 32'(out_last), 32'd0);
        st0 = st_cnt;
        repeat (20) @(negedge clock);
        check("mid_rst_no_start", 32'(st_cnt - st0), 32'd0);
        check("mid_rst_fifo_empty", 32'(busy), 32'd0);
        kern_delay = 3;
        push_sample(16'h7777, 16'h8888, 1'b0);
        wait_drain();
        check("mid_rst_restart", 32'(st_cnt - st0), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/clink_seq_sched.md
Name: clink_seq_sched

Overview:
- Sequencer in front of the Clink LSTM kernel. Buffers a stream of 16-bit input samples in a small FIFO and drives the kernel's start/finish handshake once per sample.
- Holds `clink_input` stable for the whole kernel step and captures `clink_output` on finish. Returns either every step's output or only the sequence's final output on a valid/ready stream.
- Counts steps per sequence, flags kernel hangs with a watchdog, and sits between the host/DMA stream and the Clink top.

Parameters:
- FIFO_DEPTH, 8, input FIFO entries; power of two, ≥2.
- SEQ_W, 8, width of the sequence-length and step counters.
- TIMEOUT_CYC, 1023, maximum cycles allowed in WAIT before a timeout error.

Ports:
- clock  in  1  sole clock
- reset  in  1  synchronous, active-high reset
- cfg_seq_len  in  SEQ_W  steps per sequence; 0 is treated as 1
- cfg_emit_all  in  1  1: emit every step's output; 0: emit only the last step's output
- clr_err  in  1  clears err_timeout
- in_valid  in  1  input sample valid
- in_ready  out  1  FIFO not full
- in_data  in  16  input sample
- out_valid  out  1  result valid
- out_ready  in  1  downstream accepts result
- out_data  out  16  captured clink_output
- out_last  out  1  result belongs to the last step of its sequence
- clink_start  out  1  one-cycle start pulse to the kernel
- clink_input  out  16  sample presented to the kernel
- clink_first  out  1  high with clink_start at step 0; lets the top clear kernel hidden state
- clink_finish  in  1  kernel step complete (pulse)
- clink_output  in  16  kernel result, valid while clink_finish is high
- busy  out  1  state != IDLE or out_valid
- seq_done  out  1  one-cycle pulse when the last step's result is accepted
- err_timeout  out  1  sticky watchdog error

Behaviour:
- Reset values: all outputs 0, except in_ready, which is 1 after the first post-reset cycle. FIFO is empty, step=0, state=IDLE.
- FIFO:
  - Push when in_valid & in_ready.
  - in_ready = !full. A push while full is not possible.
  - Pop happens only in START. Push and pop in the same cycle are both honoured.
  - Pointers wrap modulo FIFO_DEPTH; a count register disambiguates full from empty.
- State machine (registered): IDLE, START, WAIT, OUT.
  - IDLE → START when FIFO is non-empty and out_valid = 0.
  - At step 0, cfg_seq_len and cfg_emit_all are latched into len_q and emit_q. Changes to cfg_* mid-sequence have no effect.
  - START, one cycle:
    - clink_start = 1 and clink_first = (step==0).
    - clink_input is loaded from the FIFO head and held until the next START.
    - Pop the FIFO; go to WAIT.
  - WAIT:
    - On clink_finish, compute last = (step == len_q-1).
    - If emit_q | last: out_data ← clink_output, out_last ← last, out_valid ← 1, go to OUT.
    - Otherwise step++ and go to IDLE.
    - clink_finish seen outside WAIT is ignored.
  - OUT: on out_valid & out_ready:
    - out_valid ← 0.
    - If out_last: seq_done pulses and step ← 0; otherwise step++.
    - Go to IDLE.
    - out_data and out_last stay stable while out_valid=1 & !out_ready.
- Latency:
  - A sample accepted into an empty FIFO at cycle N, with state IDLE, produces clink_start at N+2.
  - clink_finish at cycle M produces out_valid at M+1.
- Watchdog:
  - wd counts cycles in WAIT and clears on entry to WAIT.
  - If wd reaches TIMEOUT_CYC without clink_finish: err_timeout ← 1, step ← 0, abort to IDLE. The sample is dropped, no output is produced, and the FIFO is kept.
  - A late clink_finish is ignored.
- clr_err clears err_timeout; if a timeout occurs in the same cycle, the set wins.
- cfg_seq_len = 0 behaves as 1: every output has out_last=1 and seq_done pulses per sample.
- Step counter width is SEQ_W; len_q = 2^SEQ_W-1 is the maximum supported length.
- Reset mid-operation: the FIFO is flushed and any in-flight kernel step is abandoned. The top ties the kernel's reset_n to !reset so both restart together.

Decomposition:
- Package clink_sched_pkg: state enum (IDLE, START, WAIT, OUT), CLINK_DW=16, default SEQ_W, TIMEOUT_CYC.
- Sub-module clink_sched_fifo: synchronous single-clock FIFO, parameters FIFO_DEPTH and width 16, ports push/pop/full/empty/head. Reused elsewhere for parameter streams.

Test Plan:
- Single step: cfg_seq_len=1, push 0x1234; kernel model finishes 12 cycles after start with 0x0ABC → clink_input=0x1234, clink_first=1, out_data=0x0ABC, out_last=1, seq_done pulses once.
- Many-to-one: cfg_seq_len=4, emit_all=0, push 4 samples; model returns 0x0001..0x0004 → 4 start pulses with clink_first only on the first; a single output 0x0004 with out_last=1.
- Backpressure and full FIFO: emit_all=1, out_ready=0, push 10 samples with FIFO_DEPTH=8 → in_ready drops after 8+1 accepted; one out_valid held stable; releasing out_ready drains all 10 in order.
- Timeout: model never finishes → err_timeout=1 after exactly TIMEOUT_CYC WAIT cycles; next sample starts with clink_first=1; clr_err clears the flag.
- Config latch and edge cases: cfg_seq_len changes from 3 to 5 at step 1 → the sequence still ends after 3; cfg_seq_len=0 → out_last=1 on every output.
- Reset mid-WAIT with 3 samples queued → all outputs 0 the next cycle, FIFO empty, no clink_start until new pushes arrive.
